tcp_tx_route_tagger: RTL and testbench

TCP_TX_ROUTE_TAGGER -- requirements
Module: tcp_tx_route_tagger

---
 rtl/tcp_tx_route_tagger.sv | 85 ++++++++
 tb/tb_tcp_tx_route_tagger.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_route_tagger.sv
// tcp_tx_route_tagger: tags each TX AXIS packet with the next queued route_id on m_axis_tdest.
// One bubble cycle per packet pops the route FIFO; beats then pass straight through.
module tcp_tx_route_tagger #(
    parameter  int ROUTE_BITS  = 14,
    parameter  int ROUTE_DEPTH = 8,
    parameter  int DATA_BITS   = 512,
    localparam int PTR_BITS    = $clog2(ROUTE_DEPTH),
    localparam int LVL_BITS    = PTR_BITS + 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [ROUTE_BITS-1:0]  s_route_id,
    input  logic                   s_route_id_valid,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    output logic [ROUTE_BITS-1:0]  m_axis_tdest,
    input  logic                   m_axis_tready,
    output logic                   route_ovf,
    output logic [31:0]            pkt_cnt,
    output logic [LVL_BITS-1:0]    route_level
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state, next_state;
    logic [ROUTE_BITS-1:0] fifo_mem [ROUTE_DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr, wr_ptr;
    logic                  pop, full, push_ok, pkt_end;

    assign full    = route_level == LVL_BITS'(ROUTE_DEPTH);
    assign push_ok = s_route_id_valid && (!full || pop);
    assign pkt_end = (state == STREAM) && s_axis_tvalid && m_axis_tready && s_axis_tlast;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;

    always_comb begin
        next_state    = state;
        pop           = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        if (state == IDLE) begin
            if (s_axis_tvalid && route_level != '0) begin
                next_state = STREAM;
                pop        = 1'b1;
            end
        end else begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            if (pkt_end) next_state = IDLE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            route_level  <= '0;
            m_axis_tdest <= '0;
            pkt_cnt      <= '0;
            route_ovf    <= 1'b0;
        end else begin
            state       <= next_state;
            rd_ptr      <= rd_ptr + PTR_BITS'(pop);
            wr_ptr      <= wr_ptr + PTR_BITS'(push_ok);
            route_level <= route_level + LVL_BITS'(push_ok) - LVL_BITS'(pop);
            route_ovf   <= route_ovf | (s_route_id_valid & full & ~pop);
            pkt_cnt     <= pkt_cnt + 32'(pkt_end);
            if (pop) m_axis_tdest <= fifo_mem[rd_ptr];
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (push_ok) fifo_mem[wr_ptr] <= s_route_id;
    end
endmodule

// File: tb/tb_tcp_tx_route_tagger.sv
// tb_tcp_tx_route_tagger: directed checks of route queueing, tagging, stalls, overflow and reset.
module tb_tcp_tx_route_tagger;
    localparam int RB = 14;
    localparam int RD = 8;
    localparam int DB = 32;
    localparam int KB = DB / 8;
    localparam int LB = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [RB-1:0] s_route_id = '0;
    logic          s_route_id_valid = 1'b0;
    logic [DB-1:0] s_axis_tdata = '0;
    logic [KB-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DB-1:0] m_axis_tdata;
    logic [KB-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic [RB-1:0] m_axis_tdest;
    logic          m_axis_tready = 1'b1;
    logic          route_ovf;
    logic [31:0]   pkt_cnt;
    logic [LB-1:0] route_level;

    int vectors = 0;
    int miscompares = 0;

    tcp_tx_route_tagger #(.ROUTE_BITS(RB), .ROUTE_DEPTH(RD), .DATA_BITS(DB)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_route_id(s_route_id), .s_route_id_valid(s_route_id_valid),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tready(m_axis_tready),
        .route_ovf(route_ovf), .pkt_cnt(pkt_cnt), .route_level(route_level)
    );

    always #5 aclk = ~aclk;

    task automatic clk1;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_level"}, 64'(route_level), 64'd0);
        chk({tag, "_ovf"}, 64'(route_ovf), 64'd0);
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        chk({tag, "_tdest"}, 64'(m_axis_tdest), 64'd0);
    endtask

    task automatic do_reset;
        aresetn = 1'b0;
        s_route_id_valid = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        clk1;
        clk1;
        check_reset("reset");
        aresetn = 1'b1;
    endtask

    task automatic push(input logic [RB-1:0] id);
        s_route_id = id;
        s_route_id_valid = 1'b1;
        clk1;
        s_route_id_valid = 1'b0;
    endtask

    // Sends one n-beat packet; exp_wait is the number of IDLE cycles before the first beat shows.
    task automatic run_pkt(input string tag, input logic [RB-1:0] dest, input int n,
                           input logic [DB-1:0] base, input bit rnd, input int exp_wait);
        int waits = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = base;
        s_axis_tkeep = KB'(1);
        s_axis_tlast = (n == 1);
        #1;
        while (!m_axis_tvalid && waits < 40) begin
            clk1;
            waits++;
        end
        chk({tag, "_wait"}, 64'(waits), 64'(exp_wait));
        for (int i = 0; i < n;) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tdata = base + DB'(i);
            s_axis_tkeep = KB'(i + 1);
            s_axis_tlast = (i == n - 1);
            #1;
            chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd1);
            chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'(base + DB'(i)));
            chk({tag, "_tkeep"}, 64'(m_axis_tkeep), 64'(i + 1));
            chk({tag, "_tdest"}, 64'(m_axis_tdest), 64'(dest));
            chk({tag, "_tready"}, 64'(s_axis_tready), 64'(m_axis_tready));
            if (m_axis_tready) i++;
            clk1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    initial begin
        do_reset;

        // Basic 3-beat packet; first beat one cycle after leaving IDLE
        push(14'h0A5);
        chk("t1_level_push", 64'(route_level), 64'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'hA000;
        s_axis_tkeep = 4'hF;
        s_axis_tlast = 1'b0;
        #1;
        chk("t1_idle_tready", 64'(s_axis_tready), 64'd0);
        chk("t1_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        clk1;
        chk("t1_level_pop", 64'(route_level), 64'd0);
        chk("t1_b0_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("t1_b0_tdest", 64'(m_axis_tdest), 64'h0A5);
        chk("t1_b0_tdata", 64'(m_axis_tdata), 64'hA000);
        chk("t1_b0_tready", 64'(s_axis_tready), 64'd1);
        clk1;
        s_axis_tdata = 32'hA001;
        #1;
        chk("t1_b1_tdata", 64'(m_axis_tdata), 64'hA001);
        chk("t1_b1_tdest", 64'(m_axis_tdest), 64'h0A5);
        clk1;
        s_axis_tdata = 32'hA002;
        s_axis_tlast = 1'b1;
        #1;
        chk("t1_b2_tlast", 64'(m_axis_tlast), 64'd1);
        chk("t1_b2_tdata", 64'(m_axis_tdata), 64'hA002);
        clk1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        #1;
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t1_done_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t1_done_tdest", 64'(m_axis_tdest), 64'h0A5);

        // Packet waits on an empty FIFO, route arrives late
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'hB000;
        s_axis_tlast = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("nr_stall_%0d", i), 64'(s_axis_tready), 64'd0);
            if (i == 9) begin
                s_route_id = 14'h123;
                s_route_id_valid = 1'b1;
            end
            clk1;
        end
        s_route_id_valid = 1'b0;
        #1;
        chk("nr_stall_10", 64'(s_axis_tready), 64'd0);
        chk("nr_level", 64'(route_level), 64'd1);
        run_pkt("nr", 14'h123, 1, 32'hB000, 1'b0, 1);
        chk("nr_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // Overflow: 9 pushes into depth 8, 9th dropped
        for (int k = 1; k <= 9; k++) push(RB'(k));
        chk("ovf_level", 64'(route_level), 64'd8);
        chk("ovf_flag", 64'(route_ovf), 64'd1);
        for (int k = 1; k <= 8; k++)
            run_pkt($sformatf("ovf_%0d", k), RB'(k), 2, 32'hC000 + DB'(k * 16), 1'b0, 1);
        chk("ovf_drained", 64'(route_level), 64'd0);
        s_axis_tvalid = 1'b1;
        repeat (3) clk1;
        chk("ovf_no9th", 64'(m_axis_tvalid), 64'd0);
        s_axis_tvalid = 1'b0;
        chk("ovf_sticky", 64'(route_ovf), 64'd1);
        chk("ovf_pkt_cnt", 64'(pkt_cnt), 64'd10);

        // Reset mid-packet with routes still queued
        for (int k = 0; k < 4; k++) push(RB'(16 + k));
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'hD000;
        s_axis_tlast = 1'b0;
        clk1;
        chk("rst_pre_tdest", 64'(m_axis_tdest), 64'h10);
        chk("rst_pre_level", 64'(route_level), 64'd3);
        clk1;
        s_axis_tdata = 32'hD001;
        aresetn = 1'b0;
        #1;
        check_reset("rst_mid");
        clk1;
        aresetn = 1'b1;
        repeat (3) clk1;
        chk("rst_after_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_after_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_after_level", 64'(route_level), 64'd0);
        push(14'h2AB);
        run_pkt("rst_fresh", 14'h2AB, 2, 32'hE000, 1'b0, 1);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Push coincident with a pop while full
        for (int k = 0; k < 8; k++) push(RB'(48 + k));
        chk("full_level", 64'(route_level), 64'd8);
        chk("full_ovf", 64'(route_ovf), 64'd0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'hF000;
        s_axis_tlast = 1'b0;
        s_route_id = 14'h38;
        s_route_id_valid = 1'b1;
        clk1;
        s_route_id_valid = 1'b0;
        #1;
        chk("full_pp_level", 64'(route_level), 64'd8);
        chk("full_pp_ovf", 64'(route_ovf), 64'd0);
        chk("full_pp_tdest", 64'(m_axis_tdest), 64'h30);
        run_pkt("full_pop", 14'h30, 2, 32'hF000, 1'b0, 0);
        for (int k = 1; k <= 8; k++)
            run_pkt($sformatf("full_%0d", k), RB'(48 + k), 1, 32'hF100 + DB'(k), 1'b0, 1);
        chk("full_drained", 64'(route_level), 64'd0);
        chk("full_ovf_end", 64'(route_ovf), 64'd0);
        chk("full_pkt_cnt", 64'(pkt_cnt), 64'd10);

        // 100 packets under random downstream backpressure
        do_reset;
        for (int k = 0; k < 100; k++) begin
            push(RB'(512 + k));
            run_pkt($sformatf("rnd_%0d", k), RB'(512 + k), 1 + k % 4, DB'(k) << 8, 1'b1, 1);
        end
        chk("rnd_pkt_cnt", 64'(pkt_cnt), 64'd100);
        chk("rnd_level", 64'(route_level), 64'd0);
        chk("rnd_ovf", 64'(route_ovf), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
